// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU-side memory arbiter: FSM encoding and the
// value forced into the byte-offset bits when word-aligning an address.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DREQ  = 3'd1,
    DWAIT = 3'd2,
    IREQ  = 3'd3,
    IWAIT = 3'd4
  } state_t;

  localparam logic [1:0] WORD_MASK = 2'b00;

endpackage

// File: rtl/mem_req_latch.sv
// Capture registers for the fetch and data requests seen while the arbiter
// is idle; addresses are stored already word-aligned.
module mem_req_latch
  import mem_arbiter_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture,
  input  logic [AW-1:0] icache_addr,
  input  logic          icache_re,
  input  logic [AW-1:0] dcache_addr,
  input  logic          dcache_re,
  input  logic [3:0]    dcache_we,
  input  logic [31:0]   dcache_din,
  output logic [AW-1:0] i_addr,
  output logic [AW-1:0] d_addr,
  output logic [3:0]    d_we,
  output logic [31:0]   d_din,
  output logic          i_pend,
  output logic          d_pend
);

  always_ff @(posedge clk) begin
    if (rst) begin
      i_addr <= '0;
      d_addr <= '0;
      d_we   <= '0;
      d_din  <= '0;
      i_pend <= 1'b0;
      d_pend <= 1'b0;
    end else if (capture) begin
      i_addr <= {icache_addr[AW-1:2], WORD_MASK};
      d_addr <= {dcache_addr[AW-1:2], WORD_MASK};
      d_we   <= dcache_we;
      d_din  <= dcache_din;
      i_pend <= icache_re;
      d_pend <= dcache_re | (|dcache_we);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises a cycle's data access and instruction fetch onto one memory
// channel, data first; stalls the CPU until both have completed.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] icache_addr,
  input  logic          icache_re,
  input  logic [AW-1:0] dcache_addr,
  input  logic          dcache_re,
  input  logic [3:0]    dcache_we,
  input  logic [31:0]   dcache_din,
  output logic [31:0]   instruction,
  output logic [31:0]   dcache_dout,
  output logic          stall,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_req_addr,
  output logic [3:0]    mem_req_we,
  output logic [31:0]   mem_req_wdata,
  input  logic          mem_resp_valid,
  input  logic [31:0]   mem_resp_data
);

  state_t        state, nxt;
  logic [AW-1:0] i_addr, d_addr;
  logic [3:0]    d_we;
  logic [31:0]   d_din;
  logic          i_pend, d_pend;
  logic          ld_i, ld_d;
  logic          d_req_in;

  assign d_req_in = dcache_re | (|dcache_we);

  mem_req_latch #(.AW(AW)) u_latch (
    .clk         (clk),
    .rst         (rst),
    .capture     (state == IDLE),
    .icache_addr (icache_addr),
    .icache_re   (icache_re),
    .dcache_addr (dcache_addr),
    .dcache_re   (dcache_re),
    .dcache_we   (dcache_we),
    .dcache_din  (dcache_din),
    .i_addr      (i_addr),
    .d_addr      (d_addr),
    .d_we        (d_we),
    .d_din       (d_din),
    .i_pend      (i_pend),
    .d_pend      (d_pend)
  );

  assign stall         = (state != IDLE);
  assign mem_req_addr  = (state == IREQ || state == IWAIT) ? i_addr : d_addr;
  assign mem_req_wdata = d_din;

  always_comb begin
    nxt           = state;
    mem_req_valid = 1'b0;
    mem_req_we    = 4'b0000;
    ld_i          = 1'b0;
    ld_d          = 1'b0;
    case (state)
      IDLE: begin
        // Decision uses the live inputs so the first request issues right
        // after the capture edge.
        if (d_req_in)       nxt = DREQ;
        else if (icache_re) nxt = IREQ;
      end
      DREQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = d_we;
        if (mem_req_ready) nxt = DWAIT;
      end
      DWAIT: begin
        if (mem_resp_valid) begin
          ld_d = d_pend && (d_we == 4'b0000);
          nxt  = i_pend ? IREQ : IDLE;
        end
      end
      IREQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) nxt = IWAIT;
      end
      IWAIT: begin
        if (mem_resp_valid) begin
          ld_i = 1'b1;
          nxt  = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instruction <= '0;
      dcache_dout <= '0;
    end else begin
      state <= nxt;
      if (ld_i) instruction <= mem_resp_data;
      if (ld_d) dcache_dout <= mem_resp_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: the bench plays CPU and memory, queues the
// read data it returns and compares it once the stall drops.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] icache_addr, dcache_addr, dcache_din;
  logic        icache_re, dcache_re;
  logic [3:0]  dcache_we;
  logic [31:0] instruction, dcache_dout;
  logic        stall, mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_we;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  typedef struct packed {
    logic        is_i;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          stall_cnt = 0;
  logic [31:0] exp_instr = 32'h0;
  logic [31:0] exp_dout = 32'h0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_addr    (icache_addr),
    .icache_re      (icache_re),
    .dcache_addr    (dcache_addr),
    .dcache_re      (dcache_re),
    .dcache_we      (dcache_we),
    .dcache_din     (dcache_din),
    .instruction    (instruction),
    .dcache_dout    (dcache_dout),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_we     (mem_req_we),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  // Advance one cycle, counting the cycle being left if stall was high in it.
  task automatic tick();
    @(negedge clk);
    if (stall) stall_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_quiet();
    icache_re = 1'b0;
    dcache_re = 1'b0;
    dcache_we = 4'b0000;
  endtask

  // Memory side of one transaction: check the request, hold off nr cycles,
  // accept, then respond lat cycles after acceptance.
  task automatic serve(input bit is_i, input int nr, input int lat, input bit stray,
                       input logic [31:0] rdata, input logic [31:0] eaddr,
                       input logic [3:0] ewe, input logic [31:0] ewd);
    int n = 0;
    while (!mem_req_valid && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (mem_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL req_timeout: valid=%b required 1 within 20 cycles", mem_req_valid);
      return;
    end
    total++;
    if (mem_req_addr !== eaddr || mem_req_we !== ewe || (ewe != 4'b0 && mem_req_wdata !== ewd)) begin
      bad++;
      $display("FAIL req_fields: addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
               mem_req_addr, mem_req_we, mem_req_wdata, eaddr, ewe, ewd);
    end
    for (int k = 0; k < nr; k++) begin
      mem_req_ready = 1'b0;
      if (stray) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_BAD0;
      end
      tick();
      mem_resp_valid = 1'b0;
      total++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== eaddr || mem_req_we !== ewe ||
          (ewe != 4'b0 && mem_req_wdata !== ewd)) begin
        bad++;
        $display("FAIL req_hold: cycle=%0d valid=%b addr=%h we=%b wdata=%h required 1 %h %b %h",
                 k, mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, eaddr, ewe, ewd);
      end
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    repeat (lat - 1) tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = rdata;
    if (ewe == 4'b0000) sb.push_back('{is_i: is_i, val: rdata});
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic check_done(input string name, input int exp_stall);
    exp_t e;
    total++;
    if (stall !== 1'b0 || stall_cnt != exp_stall) begin
      bad++;
      $display("FAIL %s_stall: stall=%b cycles=%0d required 0 and %0d cycles", name, stall, stall_cnt, exp_stall);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (e.is_i) begin
        exp_instr = e.val;
        if (instruction !== e.val) begin
          bad++;
          $display("FAIL %s_instr: got %h required %h", name, instruction, e.val);
        end
      end else begin
        exp_dout = e.val;
        if (dcache_dout !== e.val) begin
          bad++;
          $display("FAIL %s_dout: got %h required %h", name, dcache_dout, e.val);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    icache_re = 1'b1; icache_addr = 32'h0000_0F0F;
    dcache_re = 1'b1; dcache_addr = 32'h0000_F0F0; dcache_we = 4'hF; dcache_din = 32'h1234_5678;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    tick();
    tick();
    total++;
    if (stall !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_we !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl: stall=%b valid=%b we=%b required 0 0 0", stall, mem_req_valid, mem_req_we);
    end
    total++;
    if (mem_req_addr !== 32'h0 || mem_req_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_req: addr=%h wdata=%h required 0 0", mem_req_addr, mem_req_wdata);
    end
    total++;
    if (instruction !== 32'h0 || dcache_dout !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: instr=%h dout=%h required 0 0", instruction, dcache_dout);
    end
    cpu_quiet();
    dcache_din = 32'h0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    icache_re = 1'b1; icache_addr = 32'h0000_0106;
    stall_cnt = 0;
    tick();
    cpu_quiet();
    serve(1'b1, 0, 1, 1'b0, 32'h2408_0005, 32'h0000_0104, 4'b0000, 32'h0);
    check_done("fetch", 2);
  endtask

  task automatic test_load_fetch();
    dcache_re = 1'b1; dcache_addr = 32'h1000_0008;
    icache_re = 1'b1; icache_addr = 32'h0000_0040;
    stall_cnt = 0;
    tick();
    cpu_quiet();
    serve(1'b0, 0, 1, 1'b0, 32'h1111_2222, 32'h1000_0008, 4'b0000, 32'h0);
    serve(1'b1, 0, 1, 1'b0, 32'h3333_4444, 32'h0000_0040, 4'b0000, 32'h0);
    check_done("load_fetch", 4);
  endtask

  // dcache_re is also set: a write wins and the read data path stays put.
  task automatic test_store();
    dcache_re = 1'b1; dcache_we = 4'b0011;
    dcache_addr = 32'h2000_0013; dcache_din = 32'h0000_ABCD;
    stall_cnt = 0;
    tick();
    cpu_quiet();
    serve(1'b0, 0, 1, 1'b0, 32'hFFFF_0000, 32'h2000_0010, 4'b0011, 32'h0000_ABCD);
    check_done("store", 2);
    total++;
    if (dcache_dout !== exp_dout) begin
      bad++;
      $display("FAIL store_dout: got %h required %h", dcache_dout, exp_dout);
    end
  endtask

  task automatic test_backpressure();
    dcache_re = 1'b1; dcache_addr = 32'h3000_0004; dcache_din = 32'h0;
    stall_cnt = 0;
    tick();
    dcache_addr = 32'hFFFF_FFF0; icache_addr = 32'hEEEE_EEE0; dcache_din = 32'h7777_7777;
    serve(1'b0, 3, 1, 1'b1, 32'h5555_AAAA, 32'h3000_0004, 4'b0000, 32'h0);
    cpu_quiet();
    check_done("backpressure", 5);
  endtask

  task automatic test_latency();
    icache_re = 1'b1; icache_addr = 32'h0000_0203;
    stall_cnt = 0;
    tick();
    cpu_quiet();
    serve(1'b1, 0, 3, 1'b0, 32'h0BAD_F00D, 32'h0000_0200, 4'b0000, 32'h0);
    check_done("latency", 4);
  endtask

  task automatic test_idle();
    cpu_quiet();
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (stall !== 1'b0 || mem_req_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle_quiet: cycle=%0d stall=%b valid=%b required 0 0", k, stall, mem_req_valid);
      end
    end
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_0001;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    total++;
    if (instruction !== exp_instr || dcache_dout !== exp_dout || stall !== 1'b0) begin
      bad++;
      $display("FAIL idle_stray: instr=%h dout=%h stall=%b required %h %h 0",
               instruction, dcache_dout, stall, exp_instr, exp_dout);
    end
  endtask

  task automatic test_reset_mid();
    dcache_re = 1'b1; dcache_addr = 32'h4000_0000;
    icache_re = 1'b1; icache_addr = 32'h0000_0080;
    tick();
    cpu_quiet();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_instr = 32'h0;
    exp_dout  = 32'h0;
    total++;
    if (stall !== 1'b0 || mem_req_valid !== 1'b0 || instruction !== 32'h0 || dcache_dout !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid: stall=%b valid=%b instr=%h dout=%h required 0 0 0 0",
               stall, mem_req_valid, instruction, dcache_dout);
    end
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    total++;
    if (dcache_dout !== 32'h0 || instruction !== 32'h0 || stall !== 1'b0 || mem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_late_resp: dout=%h instr=%h stall=%b valid=%b required 0 0 0 0",
               dcache_dout, instruction, stall, mem_req_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load_fetch();
    test_store();
    test_backpressure();
    test_latency();
    test_idle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that sits directly downstream of the CPU's icache/dcache request ports. It serialises each cycle's instruction-fetch and data access onto one backing-memory request/response channel. It returns `instruction`/`dcache_dout` with synchronous-read semantics and drives the CPU's `stall` input while accesses are outstanding.

## Interface

**Parameters**
- `AW`, default 32: address width of CPU and memory ports.

**Ports**
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `icache_addr` in AW: fetch byte address.
- `icache_re` in 1: fetch request.
- `dcache_addr` in AW: data byte address.
- `dcache_re` in 1: data read request.
- `dcache_we` in 4: data byte write mask.
- `dcache_din` in 32: write data, already lane-aligned.
- `instruction` out 32: fetched word.
- `dcache_dout` out 32: read word.
- `stall` out 1: CPU freeze.
- `mem_req_valid` out 1: memory request valid.
- `mem_req_ready` in 1: memory accepts request.
- `mem_req_addr` out AW: word-aligned address, `{addr[AW-1:2],2'b00}`.
- `mem_req_we` out 4: byte mask; 0 means read.
- `mem_req_wdata` out 32: write data.
- `mem_resp_valid` in 1: one response per accepted request, reads and writes alike.
- `mem_resp_data` in 32: read data (ignored for writes).

## Operation

**States:** IDLE, DREQ, DWAIT, IREQ, IWAIT.

**`stall`** = (state != IDLE). It is combinational from state only; there is no combinational path from any input.

**IDLE capture.** In IDLE, on each clock edge latch `icache_addr`, `icache_re`, `dcache_addr`, `dcache_re`, `dcache_we`, `dcache_din`. Define:
- D-op pending = `dcache_re | (|dcache_we)`
- I-op pending = `icache_re`

Next state:
- DREQ if a D-op is pending.
- Otherwise IREQ if an I-op is pending.
- Otherwise stay in IDLE.

**Request inputs while `stall` is high** are ignored; the CPU re-presents the same addresses.

**DREQ.**
- `mem_req_valid` = 1, with the captured D address, `mem_req_we` = captured mask, `mem_req_wdata` = captured din.
- On `mem_req_ready`, go to DWAIT.
- `mem_req_*` are held stable until accepted.

**DWAIT.** On `mem_resp_valid`:
- If the op was a read (mask = 0), load `dcache_dout` with `mem_resp_data`.
- Then go to IREQ if an I-op was captured, else IDLE.

**Read and write together.** If `dcache_re` and `dcache_we` are both set, the op is a write and `dcache_dout` is unchanged. A write never changes `dcache_dout`.

**IREQ/IWAIT.** Same as DREQ/DWAIT, but a read only: `mem_req_we` = 0, and `instruction` loads on `mem_resp_valid`. Then go to IDLE.

**Stray responses.** `mem_resp_valid` in IDLE, DREQ or IREQ is ignored.

**Outputs outside request states.** `mem_req_valid` = 0 and `mem_req_we` = 0 in IDLE, DWAIT and IWAIT.

## Timing

**Reset values:** state = IDLE; `instruction` = 0; `dcache_dout` = 0; `stall` = 0; `mem_req_valid` = 0; `mem_req_addr` = 0; `mem_req_we` = 0; `mem_req_wdata` = 0.

**Reset mid-operation:** return to IDLE next edge; the outstanding response is dropped (ignored in IDLE); captured requests are discarded.

**Stall duration.** With `mem_req_ready` = 1 and the response one cycle after acceptance (minimum memory latency):
- Single op: `stall` is high for exactly 2 cycles.
- D + I ops: 4 cycles.
- Each extra cycle of not-ready or response latency adds one stall cycle.

**Data visibility.** Returned data is registered at the response edge and is stable on outputs in the first cycle `stall` is low. Outputs hold until the next load.

**No requests.** A cycle with no request keeps `stall` low indefinitely (zero overhead).

**Response timing rules:**
- A response in the same cycle as acceptance is illegal (the memory contract requires at least one cycle).
- At most one request is outstanding.

## Structure

- **Shared package:** state encoding (3-bit enum IDLE=0, DREQ=1, DWAIT=2, IREQ=3, IWAIT=4) and the word-align helper constant `WORD_MASK`.
- **Sub-module `mem_req_latch`:** the capture register set (addr/mask/data, plus pending flags for D and I). It holds the per-op request fields so the top-level is the FSM plus output muxing.

## Test plan

- **Reset:** assert `rst` mid-DWAIT, then deassert → next cycle state IDLE, `stall` = 0, `mem_req_valid` = 0, both outputs 0; a late `mem_resp_valid` with 0xDEADBEEF leaves `dcache_dout` = 0.
- **Fetch only:** `icache_re` = 1, `icache_addr` = 0x0000_0106, ready = 1, resp 1 cycle later with 0x2408_0005 → `mem_req_addr` = 0x104, `stall` high 2 cycles, `instruction` = 0x24080005 when `stall` falls.
- **Load + fetch:** `dcache_re` at 0x1000_0008 and `icache_re` at 0x40 → data request issued first, then fetch; `stall` high 4 cycles; `dcache_dout`/`instruction` get the respective responses.
- **Store:** `dcache_we` = 4'b0011, din = 0x0000_ABCD → `mem_req_we` = 0011, wdata = 0x0000ABCD; `dcache_dout` unchanged; `stall` ends one cycle after the ack.
- **Backpressure:** `mem_req_ready` low for 3 cycles → `mem_req_addr`/`we`/`wdata` stable throughout, `stall` high 5 cycles total; changing CPU addresses during the stall has no effect.
- **Idle:** no requests for 10 cycles → `stall` = 0, `mem_req_valid` = 0 throughout; a stray `mem_resp_valid` leaves both outputs unchanged.
